// File: rtl/sigma_dma_if.sv
// rtl/sigma_dma_if.sv - MemSplit32 bus bundle: initiator drives req/we/addr/be/wdata, target returns ack/resp/rdata
interface sigma_dma_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/sigma_dma.sv
// rtl/sigma_dma.sv - single-channel MemSplit32 word-copy engine; read timeout enabled by SIGMA_DMA_TIMEOUT_EN
module sigma_dma #(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    sigma_dma_if.master          bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [29:0]          r_src;
    logic [29:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [31:0]          r_addr;
    logic                 r_we;
    logic [3:0]           r_be;
    logic [31:0]          r_wdata;
    logic                 w_timeout;
    logic                 w_last;
    logic                 w_unused;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sigma_dma: TIMEOUT must be at least 1");
    end

    // Byte-lane bits of the addresses are meaningless for word copies.
    assign w_unused = ^{src_addr_i[1:0], dst_addr_i[1:0]};
    assign w_last   = (r_cnt == LEN_WIDTH'(1));

`ifdef SIGMA_DMA_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] r_tmo;
    logic          r_err;

    // A response in the same cycle the limit is hit still wins.
    assign w_timeout = (r_state == S_RD_WAIT) && !bus.resp && (r_tmo == TW'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (!rst_i || r_state != S_RD_WAIT) begin
            r_tmo <= '0;
        end else if (!bus.resp) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (len_i != '0) ? S_RD_REQ : S_DONE;
                end
            end
            S_RD_REQ: begin
                if (bus.ack) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.resp) begin
                    w_next = S_WR_REQ;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if (bus.ack) begin
                    w_next = w_last ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus attributes are loaded on the way into each request state so they
    // are already stable in the first req cycle and frozen through stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && len_i != '0) begin
                        r_src  <= src_addr_i[31:2];
                        r_dst  <= dst_addr_i[31:2];
                        r_cnt  <= len_i;
                        r_addr <= {src_addr_i[31:2], 2'b00};
                        r_we   <= 1'b0;
                        r_be   <= 4'hF;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.resp) begin
                        r_wdata <= bus.rdata;
                        r_addr  <= {r_dst, 2'b00};
                        r_we    <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (bus.ack) begin
                        r_src <= r_src + 30'd1;
                        r_dst <= r_dst + 30'd1;
                        r_cnt <= r_cnt - 1'b1;
                        if (!w_last) begin
                            r_addr <= {r_src + 30'd1, 2'b00};
                            r_we   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign bus.we    = r_we;
    assign bus.addr  = r_addr;
    assign bus.be    = r_be;
    assign bus.wdata = r_wdata;

    assign busy_o = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_WR_REQ);
    assign done_o = (r_state == S_DONE);

endmodule

// File: tb/tb_sigma_dma.sv
// tb/tb_sigma_dma.sv - directed self-checking bench for sigma_dma with a stallable memory target
`timescale 1ns/1ps
module tb_sigma_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sigma_dma_if bus ();

    sigma_dma #(.LEN_WIDTH(16), .TIMEOUT(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .bus        (bus)
    );

    // Memory target: ack after a programmable number of stall cycles, resp one cycle after read accept.
    logic [31:0] mem [int unsigned];
    logic [31:0] rd_addrs [$];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wait_cnt = 0;
    int need;
    int stall_rd_idx = -1;
    int stall_rd_n = 0;
    int stall_wr_idx = -1;
    int stall_wr_n = 0;
    bit resp_en = 1'b1;

    always_comb begin
        need = 0;
        if (bus.req && !bus.we && rd_cnt == stall_rd_idx) need = stall_rd_n;
        if (bus.req && bus.we && wr_cnt == stall_wr_idx) need = stall_wr_n;
        bus.ack = bus.req && (wait_cnt >= need);
    end

    always @(posedge clk) begin
        bus.resp <= 1'b0;
        if (bus.req && !bus.ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.req && bus.ack) begin
            if (bus.we) begin
                mem[bus.addr >> 2] = bus.wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_addrs.push_back(bus.addr);
                bus.resp  <= resp_en;
                bus.rdata <= mem.exists(bus.addr >> 2) ? mem[bus.addr >> 2] : 32'hDEAD_BEEF;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] rd_mem(input logic [31:0] byte_addr);
        return mem.exists(byte_addr >> 2) ? mem[byte_addr >> 2] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next edge (N), k=1 is cycle N+1.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int pulse_at, output int done_k, output int busy_n,
                            output int req_n, output int stab_bad);
        logic        ps;
        logic        pwe;
        logic [31:0] pa;
        logic [31:0] pw;
        done_k = -1; busy_n = 0; req_n = 0; stab_bad = 0;
        ps = 1'b0; pwe = 1'b0; pa = '0; pw = '0;
        src = s; dst = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src = 32'h5555_5550; dst = 32'h6666_6660; len = 16'd9;
        for (int k = 1; k <= 200; k++) begin
            start = (k == pulse_at);
            if (done) begin
                done_k = k;
                break;
            end
            if (busy) busy_n++;
            if (bus.req) req_n++;
            if (ps && bus.req && (bus.addr !== pa || bus.we !== pwe || bus.wdata !== pw)) stab_bad++;
            ps = bus.req && !bus.ack; pa = bus.addr; pwe = bus.we; pw = bus.wdata;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(bus.req),  32'd0);
        chk({tag, "_we"},    32'(bus.we),   32'd0);
        chk({tag, "_addr"},  bus.addr,      32'd0);
        chk({tag, "_be"},    32'(bus.be),   32'd0);
        chk({tag, "_wdata"}, bus.wdata,     32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dk, bn, rn, sb, base, err_n, done_n;
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Four-word zero-wait copy.
        for (int i = 0; i < 4; i++) mem[(32'h100 >> 2) + i] = 32'hA0 + i;
        run_xfer(32'h100, 32'h200, 16'd4, 0, dk, bn, rn, sb);
        chk("copy4_done_cycle", 32'(dk), 32'd13);
        chk("copy4_busy_cycles", 32'(bn), 32'd12);
        chk("copy4_req_cycles", 32'(rn), 32'd8);
        for (int i = 0; i < 4; i++) chk($sformatf("copy4_mem%0d", i), rd_mem(32'h200 + 4 * i), 32'hA0 + i);
        chk("copy4_be", 32'(bus.be), 32'hF);

        // Zero length completes immediately without touching the bus.
        run_xfer(32'h100, 32'h300, 16'd0, 0, dk, bn, rn, sb);
        chk("len0_done_cycle", 32'(dk), 32'd1);
        chk("len0_req_cycles", 32'(rn), 32'd0);
        chk("len0_busy_cycles", 32'(bn), 32'd0);

        // Stalls: 3 cycles on the 2nd read, 2 cycles on the 1st write.
        mem[32'h300 >> 2] = 32'hB0;
        mem[32'h304 >> 2] = 32'hB1;
        stall_rd_idx = rd_cnt + 1; stall_rd_n = 3;
        stall_wr_idx = wr_cnt;     stall_wr_n = 2;
        run_xfer(32'h300, 32'h400, 16'd2, 0, dk, bn, rn, sb);
        stall_rd_idx = -1; stall_wr_idx = -1;
        chk("stall_done_cycle", 32'(dk), 32'd12);
        chk("stall_stable", 32'(sb), 32'd0);
        chk("stall_req_cycles", 32'(rn), 32'd9);
        chk("stall_mem0", rd_mem(32'h400), 32'hB0);
        chk("stall_mem1", rd_mem(32'h404), 32'hB1);

        // Reset in RD_WAIT of word 2 of 4, then a fresh single-word copy.
        for (int i = 0; i < 4; i++) mem[(32'h800 >> 2) + i] = 32'hC0 + i;
        src = 32'h800; dst = 32'h900; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_rd_wait_busy", 32'(busy), 32'd1);
        chk("abort_in_rd_wait_req", 32'(bus.req), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        chk("abort_word1_written", rd_mem(32'h900), 32'hC0);
        rst_n = 1'b1;
        @(negedge clk);
        mem[32'hA00 >> 2] = 32'hC5;
        run_xfer(32'hA00, 32'hB00, 16'd1, 0, dk, bn, rn, sb);
        chk("after_abort_done_cycle", 32'(dk), 32'd4);
        chk("after_abort_mem", rd_mem(32'hB00), 32'hC5);

        // Source address wrap and an ignored mid-transfer start pulse.
        mem[32'h3FFF_FFFF] = 32'hD0;
        mem[32'h0] = 32'hD1;
        base = rd_addrs.size();
        run_xfer(32'hFFFF_FFFC, 32'hC00, 16'd2, 3, dk, bn, rn, sb);
        chk("wrap_done_cycle", 32'(dk), 32'd7);
        chk("wrap_rd_addr0", (rd_addrs.size() > base) ? rd_addrs[base] : 32'hBAD0_BAD0, 32'hFFFF_FFFC);
        chk("wrap_rd_addr1", (rd_addrs.size() > base + 1) ? rd_addrs[base + 1] : 32'hBAD0_BAD0, 32'h0);
        chk("wrap_mem0", rd_mem(32'hC00), 32'hD0);
        chk("wrap_mem1", rd_mem(32'hC04), 32'hD1);
        chk("wrap_pulse_ignored_busy", 32'(busy), 32'd0);
        chk("wrap_read_count", 32'(rd_addrs.size() - base), 32'd2);

        // Target that never responds.
        resp_en = 1'b0;
        mem[32'hD00 >> 2] = 32'hE0;
        src = 32'hD00; dst = 32'hE00; len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_n = 0; done_n = 0;
        for (int k = 1; k <= 20; k++) begin
            if (err) err_n++;
            if (done) done_n++;
            @(negedge clk);
        end
`ifdef SIGMA_DMA_TIMEOUT_EN
        chk("timeout_err_pulses", 32'(err_n), 32'd1);
        chk("timeout_done_pulses", 32'(done_n), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_req", 32'(bus.req), 32'd0);
`else
        chk("noresp_err_pulses", 32'(err_n), 32'd0);
        chk("noresp_done_pulses", 32'(done_n), 32'd0);
        chk("noresp_busy", 32'(busy), 32'd1);
`endif
        chk("noresp_no_write", rd_mem(32'hE00), 32'hDEAD_BEEF);
        resp_en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
